// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: steps the shared datapath
// through fetch/decode/execute/memory/writeback and drives all selects/enables.
module riscv_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK, S_LUI
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t     state_q, state_d, cur_s;
    logic [1:0] alu_op;

    function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [6:0] o,
                                              input logic [2:0] f3, input logic f75);
        logic [2:0] r;
        r = 3'b000;
        if (aop == 2'b01) begin
            r = 3'b001;
        end else if (aop == 2'b10) begin
            case (f3)
                3'b000:  r = (o == OP_RTYPE && f75) ? 3'b001 : 3'b000;
                3'b111:  r = 3'b010;
                3'b110:  r = 3'b011;
                3'b010:  r = 3'b101;
                default: r = 3'b000;
            endcase
        end
        return r;
    endfunction

    // The ALU computes rs1 - rs2; funct3 picks which flag means "taken".
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic s);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return s;
            3'b101:  return ~s;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXEC_R:  state_d = S_ALUWB;
            S_EXEC_I:  state_d = S_ALUWB;
            S_JAL:     state_d = S_ALUWB;
            S_JALR:    state_d = S_JALR_LINK;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:  ImmSrc = 3'b001;
            OP_BRANCH: ImmSrc = 3'b010;
            OP_JAL:    ImmSrc = 3'b011;
            OP_LUI:    ImmSrc = 3'b100;
            default:   ImmSrc = 3'b000;
        endcase
    end

    // During reset the select outputs show FETCH values; enables are masked below.
    assign cur_s = rst ? S_FETCH : state_q;

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        case (cur_s)
            S_FETCH: begin
                IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
            end
            S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; instr_done = 1'b1; end
            S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; instr_done = 1'b1; end
            S_EXEC_R:   begin ALUSrcA = 2'b10; alu_op = 2'b10; end
            S_EXEC_I:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = 2'b10; end
            S_ALUWB:    begin RegWrite = 1'b1; instr_done = 1'b1; end
            S_BRANCH: begin
                ALUSrcA = 2'b10; alu_op = 2'b01; instr_done = 1'b1;
                PCWrite = branch_taken(funct3, zero, sign);
            end
            S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
            S_JALR: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1;
            end
            S_JALR_LINK: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                RegWrite = 1'b1; instr_done = 1'b1;
            end
            S_LUI:      begin ResultSrc = 2'b11; RegWrite = 1'b1; instr_done = 1'b1; end
            default: ;
        endcase
        if (rst) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign ALUControl = alu_decode(alu_op, op, funct3, funct7_5);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: each stimulus cycle queues the
// hand-derived output vector; a monitor compares it against the DUT mid-cycle.
module tb_riscv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0, zero = 1'b0, sign = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    riscv_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .sign(sign), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Vector layout: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc instr_done
    function automatic logic [17:0] mk(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] alu, imm, input logic done);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, done};
    endfunction

    function automatic logic [17:0] e_fetch(input logic [2:0] imm);
        return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
    endfunction

    function automatic logic [17:0] e_decode(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e   = exp_q.pop_front();
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ALUControl, ImmSrc, instr_done};
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.v);
            end
        end
    end

    task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f3,
                        input logic f75, input logic z, input logic s,
                        input logic [17:0] ev, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; op = o; funct3 = f3; funct7_5 = f75; zero = z; sign = s;
        e.v = ev;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic branch(input logic [2:0] f3, input logic z, input logic s,
                          input logic taken, input string nm);
        step(0, 7'b1100011, f3, 0, z, s, e_fetch(3'b010), {nm, "_fetch"});
        step(0, 7'b1100011, f3, 0, z, s, e_decode(3'b010), {nm, "_decode"});
        step(0, 7'b1100011, f3, 0, z, s,
             mk(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1), {nm, "_branch"});
    endtask

    localparam logic [17:0] E_RST = 18'b0_0_0_0_0_10_00_10_000_000_0;

    initial begin
        // Reset held two cycles
        step(1, 7'd0, 3'd0, 0, 0, 0, E_RST, "reset_c1");
        step(1, 7'd0, 3'd0, 0, 0, 0, E_RST, "reset_c2");

        // R-type sub
        step(0, 7'b0110011, 3'b000, 1, 1, 1, e_fetch(3'b000), "sub_fetch");
        step(0, 7'b0110011, 3'b000, 1, 1, 1, e_decode(3'b000), "sub_decode");
        step(0, 7'b0110011, 3'b000, 1, 1, 1,
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0), "sub_exec");
        step(0, 7'b0110011, 3'b000, 1, 1, 1,
             mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), "sub_aluwb");

        // R-type slt
        step(0, 7'b0110011, 3'b010, 0, 0, 0, e_fetch(3'b000), "slt_fetch");
        step(0, 7'b0110011, 3'b010, 0, 0, 0, e_decode(3'b000), "slt_decode");
        step(0, 7'b0110011, 3'b010, 0, 0, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000, 0), "slt_exec");
        step(0, 7'b0110011, 3'b010, 0, 0, 0,
             mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), "slt_aluwb");

        // I-type with bit30 set and funct3 000 stays add (addi)
        step(0, 7'b0010011, 3'b000, 1, 0, 0, e_fetch(3'b000), "addi_fetch");
        step(0, 7'b0010011, 3'b000, 1, 0, 0, e_decode(3'b000), "addi_decode");
        step(0, 7'b0010011, 3'b000, 1, 0, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0), "addi_exec");
        step(0, 7'b0010011, 3'b000, 1, 0, 0,
             mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), "addi_aluwb");

        // I-type andi and ori execute stages
        step(0, 7'b0010011, 3'b111, 0, 0, 0, e_fetch(3'b000), "andi_fetch");
        step(0, 7'b0010011, 3'b111, 0, 0, 0, e_decode(3'b000), "andi_decode");
        step(0, 7'b0010011, 3'b111, 0, 0, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0), "andi_exec");
        step(0, 7'b0010011, 3'b111, 0, 0, 0,
             mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), "andi_aluwb");
        step(0, 7'b0010011, 3'b110, 0, 0, 0, e_fetch(3'b000), "ori_fetch");
        step(0, 7'b0010011, 3'b110, 0, 0, 0, e_decode(3'b000), "ori_decode");
        step(0, 7'b0010011, 3'b110, 0, 0, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 3'b000, 0), "ori_exec");
        step(0, 7'b0010011, 3'b110, 0, 0, 0,
             mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1), "ori_aluwb");

        // lw: 5 cycles
        step(0, 7'b0000011, 3'b010, 0, 0, 0, e_fetch(3'b000), "lw_fetch");
        step(0, 7'b0000011, 3'b010, 0, 0, 0, e_decode(3'b000), "lw_decode");
        step(0, 7'b0000011, 3'b010, 0, 0, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0), "lw_memadr");
        step(0, 7'b0000011, 3'b010, 0, 0, 0,
             mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0), "lw_memread");
        step(0, 7'b0000011, 3'b010, 0, 0, 0,
             mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1), "lw_memwb");

        // sw: MemWrite in cycle 4
        step(0, 7'b0100011, 3'b010, 0, 0, 0, e_fetch(3'b001), "sw_fetch");
        step(0, 7'b0100011, 3'b010, 0, 0, 0, e_decode(3'b001), "sw_decode");
        step(0, 7'b0100011, 3'b010, 0, 0, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0), "sw_memadr");
        step(0, 7'b0100011, 3'b010, 0, 0, 0,
             mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1), "sw_memwrite");

        // Branches
        branch(3'b000, 1, 0, 1, "beq_z1");
        branch(3'b000, 0, 1, 0, "beq_z0");
        branch(3'b001, 0, 0, 1, "bne_z0");
        branch(3'b100, 0, 1, 1, "blt_s1");
        branch(3'b101, 0, 1, 0, "bge_s1");
        branch(3'b101, 1, 0, 1, "bge_s0");
        branch(3'b010, 1, 1, 0, "br_f3_010");

        // jal
        step(0, 7'b1101111, 3'b000, 0, 0, 0, e_fetch(3'b011), "jal_fetch");
        step(0, 7'b1101111, 3'b000, 0, 0, 0, e_decode(3'b011), "jal_decode");
        step(0, 7'b1101111, 3'b000, 0, 0, 0,
             mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0), "jal_jump");
        step(0, 7'b1101111, 3'b000, 0, 0, 0,
             mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 1), "jal_link");

        // jalr
        step(0, 7'b1100111, 3'b000, 0, 0, 0, e_fetch(3'b000), "jalr_fetch");
        step(0, 7'b1100111, 3'b000, 0, 0, 0, e_decode(3'b000), "jalr_decode");
        step(0, 7'b1100111, 3'b000, 0, 0, 0,
             mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0), "jalr_jump");
        step(0, 7'b1100111, 3'b000, 0, 0, 0,
             mk(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 1), "jalr_link");

        // lui
        step(0, 7'b0110111, 3'b000, 0, 0, 0, e_fetch(3'b100), "lui_fetch");
        step(0, 7'b0110111, 3'b000, 0, 0, 0, e_decode(3'b100), "lui_decode");
        step(0, 7'b0110111, 3'b000, 0, 0, 0,
             mk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1), "lui_wb");

        // Illegal opcode returns to FETCH straight after DECODE
        step(0, 7'b1111111, 3'b000, 0, 0, 0, e_fetch(3'b000), "ill_fetch");
        step(0, 7'b1111111, 3'b000, 0, 0, 0, e_decode(3'b000), "ill_decode");
        step(0, 7'b1111111, 3'b000, 0, 0, 0, e_fetch(3'b000), "ill_refetch");
        step(0, 7'b1111111, 3'b000, 0, 0, 0, e_decode(3'b000), "ill_redecode");

        // Reset in the MEMREAD cycle of a lw abandons it
        step(0, 7'b0000011, 3'b010, 0, 0, 0, e_fetch(3'b000), "lwr_fetch");
        step(0, 7'b0000011, 3'b010, 0, 0, 0, e_decode(3'b000), "lwr_decode");
        step(0, 7'b0000011, 3'b010, 0, 0, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0), "lwr_memadr");
        step(1, 7'b0000011, 3'b010, 0, 0, 0, E_RST, "lwr_reset");
        step(0, 7'b0000011, 3'b010, 0, 0, 0, e_fetch(3'b000), "lwr_after_fetch");
        step(0, 7'b0000011, 3'b010, 0, 0, 0, e_decode(3'b000), "lwr_after_decode");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
